// File: rtl/codec_init_seq.sv
// Codec register-initialisation sequencer: walks a {byte0,byte1} table and issues
// one 2-byte I2C write per entry through i2c_fsm, retrying NACKed writes.
module codec_init_seq #(
  parameter int unsigned NUM_REGS   = 8,
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned PWR_WAIT   = 16,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [3:0]  rom_idx,
  input  logic [15:0] rom_word,
  output logic        i2c_req,
  output logic [6:0]  i2c_dev_addr,
  output logic [7:0]  i2c_byte0,
  output logic [7:0]  i2c_byte1,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        init_done,
  output logic        error,
  output logic [3:0]  state_info
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    PWRUP = 4'd1,
    FETCH = 4'd2,
    ISSUE = 4'd3,
    WAIT  = 4'd4,
    GAP   = 4'd5,
    DONE  = 4'd6,
    FAIL  = 4'd7
  } state_t;

  localparam int unsigned CNT_MAX   = (PWR_WAIT > GAP_CYCLES) ? PWR_WAIT : GAP_CYCLES;
  localparam int unsigned CW        = $clog2(CNT_MAX + 2);
  localparam int unsigned RW        = $clog2(MAX_RETRY + 2);
  localparam logic [3:0]  LAST_IDX  = 4'(NUM_REGS - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_retry;
  logic          r_refetch;
  logic [3:0]    r_idx;
  logic          r_req;
  logic [7:0]    r_b0;
  logic [7:0]    r_b1;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          w_pwr_last;
  logic          w_gap_last;

  assign w_pwr_last = (32'(r_cnt) + 32'd1) >= PWR_WAIT;
  assign w_gap_last = (32'(r_cnt) + 32'd1) >= GAP_CYCLES;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_refetch <= 1'b0;
      r_idx     <= '0;
      r_req     <= 1'b0;
      r_b0      <= '0;
      r_b1      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE, FAIL: begin
          if (start) begin
            r_state <= PWRUP;
            r_cnt   <= '0;
            r_retry <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        PWRUP: begin
          if (w_pwr_last) begin
            r_state <= FETCH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FETCH: begin
          r_b0    <= rom_word[15:8];
          r_b1    <= rom_word[7:0];
          r_req   <= 1'b1;
          r_state <= ISSUE;
        end
        // A done seen while still in ISSUE (fast master) resolves exactly like WAIT.
        ISSUE, WAIT: begin
          if (i2c_done) begin
            r_req <= 1'b0;
            r_cnt <= '0;
            if (!i2c_nack) begin
              if (r_idx < LAST_IDX) begin
                r_idx     <= r_idx + 1'b1;
                r_retry   <= '0;
                r_refetch <= 1'b1;
                r_state   <= GAP;
              end else begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else if (r_retry < RETRY_LIM) begin
              r_retry   <= r_retry + 1'b1;
              r_refetch <= 1'b0;
              r_state   <= GAP;
            end else begin
              r_state <= FAIL;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end
          end else if (r_state == ISSUE && i2c_busy) begin
            r_req   <= 1'b0;
            r_state <= WAIT;
          end
        end
        // Retries re-issue the latched bytes; only a new entry goes through FETCH.
        GAP: begin
          if (w_gap_last) begin
            r_cnt <= '0;
            if (r_refetch) begin
              r_state <= FETCH;
            end else begin
              r_state <= ISSUE;
              r_req   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rom_idx      = r_idx;
  assign i2c_req      = r_req;
  assign i2c_dev_addr = DEV_ADDR;
  assign i2c_byte0    = r_b0;
  assign i2c_byte1    = r_b1;
  assign busy         = r_busy;
  assign init_done    = r_done;
  assign error        = r_err;
  assign state_info   = r_state;

endmodule
